// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing single-outstanding imem fetches into the IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        fd_flag,
  output logic        fd_pc_replace,
  output logic [31:0] fd_idata,
  output logic [31:0] fd_iaddr
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_data;
  logic        drop;
  // Fetch FSM: redirect beats response handling and stall; pc stays put in HOLD so it doubles as the buffered address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      hold_data     <= '0;
      drop          <= 1'b0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      fd_flag       <= 1'b0;
      fd_pc_replace <= 1'b0;
      fd_idata      <= '0;
      fd_iaddr      <= '0;
    end else begin
      imem_req      <= 1'b0;
      fd_flag       <= 1'b0;
      fd_pc_replace <= 1'b0;
      if (branch_taken) begin
        pc            <= {branch_target[31:2], 2'b00};
        fd_flag       <= 1'b1;
        fd_pc_replace <= 1'b1;
        if (state == WAIT && !imem_valid) begin
          drop <= 1'b1;
        end else begin
          drop  <= 1'b0;
          state <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= WAIT;
          end
          WAIT: begin
            if (imem_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= FETCH;
              end else if (stall) begin
                hold_data <= imem_rdata;
                state     <= HOLD;
              end else begin
                fd_flag  <= 1'b1;
                fd_idata <= imem_rdata;
                fd_iaddr <= pc;
                pc       <= pc + 32'd4;
                state    <= FETCH;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              fd_flag  <= 1'b1;
              fd_idata <= hold_data;
              fd_iaddr <= pc;
              pc       <= pc + 32'd4;
              state    <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus randomized run against a transaction-level fetch model
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        fd_flag;
  logic        fd_pc_replace;
  logic [31:0] fd_idata;
  logic [31:0] fd_iaddr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [logic [31:0]];
  int   lat = 1;
  bit   rand_lat = 1'b0;
  bit   mem_en = 1'b1;
  int   overlap = 0;
  int   resp_cnt = 0;
  logic [31:0] resp_addr = '0;

  if_fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .fd_flag(fd_flag),
    .fd_pc_replace(fd_pc_replace), .fd_idata(fd_idata), .fd_iaddr(fd_iaddr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A0013);
  endfunction

  // Memory model: answers each request after lat cycles, one pending request at most
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        imem_valid = 1'b0;
        if (reset) resp_cnt = 0;
        else begin
          if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
              imem_valid = 1'b1;
              imem_rdata = memf(resp_addr);
            end
          end
          if (imem_req) begin
            if (resp_cnt > 0) overlap++;
            resp_addr = imem_addr;
            resp_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_one(input logic [31:0] a, input int exp_wait, input int exp_lat);
    int n = 0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== a || (exp_wait >= 0 && n != exp_wait)) begin
      n_err++;
      $display("FAIL fetch_req: got req=%b addr=%h wait=%0d want addr=%h wait=%0d", imem_req, imem_addr, n, a, exp_wait);
    end
    n = 0;
    do begin cyc(); n++; end while (!fd_flag && n < 20);
    n_cmp++;
    if ({fd_flag, fd_pc_replace} !== 2'b10 || fd_idata !== memf(a) || fd_iaddr !== a || (exp_lat >= 0 && n != exp_lat)) begin
      n_err++;
      $display("FAIL fetch_deliver: got flag=%b rep=%b data=%h addr=%h lat=%0d want data=%h addr=%h lat=%0d",
               fd_flag, fd_pc_replace, fd_idata, fd_iaddr, n, memf(a), a, exp_lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if ({imem_req, imem_addr, fd_flag, fd_pc_replace, fd_idata, fd_iaddr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h flag=%b rep=%b data=%h iaddr=%h want all 0",
               imem_req, imem_addr, fd_flag, fd_pc_replace, fd_idata, fd_iaddr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    fetch_one(32'h0, 1, 2);
    fetch_one(32'h4, 1, 2);
  endtask

  task automatic test_stall();
    int n = 0;
    int bad = 0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL stall_req: got req=%b addr=%h want addr=00000008", imem_req, imem_addr);
    end
    stall = 1'b1;
    repeat (4) begin cyc(); if (fd_flag !== 1'b0) bad++; end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_quiet: got %0d strobes want 0", bad);
    end
    stall = 1'b0;
    cyc();
    n_cmp++;
    if ({fd_flag, fd_pc_replace} !== 2'b10 || fd_idata !== memf(32'h8) || fd_iaddr !== 32'h8) begin
      n_err++;
      $display("FAIL stall_release: got flag=%b rep=%b data=%h addr=%h want data=%h addr=00000008",
               fd_flag, fd_pc_replace, fd_idata, fd_iaddr, memf(32'h8));
    end
    fetch_one(32'hC, 1, 2);
  endtask

  task automatic test_branch_wait();
    int n = 0;
    int bad = 0;
    lat = 3;
    while (!imem_req && n < 20) begin cyc(); n++; end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL bw_req: got req=%b addr=%h want addr=00000010", imem_req, imem_addr);
    end
    branch_taken = 1'b1;
    branch_target = 32'h00000103;
    cyc();
    branch_taken = 1'b0;
    n_cmp++;
    if ({fd_flag, fd_pc_replace} !== 2'b11 || fd_idata !== memf(32'hC) || fd_iaddr !== 32'hC) begin
      n_err++;
      $display("FAIL bw_flush: got flag=%b rep=%b data=%h addr=%h want 1 1 data=%h addr=0000000c",
               fd_flag, fd_pc_replace, fd_idata, fd_iaddr, memf(32'hC));
    end
    n = 0;
    do begin cyc(); n++; if (fd_flag !== 1'b0) bad++; end while (!imem_req && n < 20);
    n_cmp++;
    if (bad != 0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL bw_redirect: got strobes=%0d req=%b addr=%h want 0 1 00000100", bad, imem_req, imem_addr);
    end
    fetch_one(32'h100, 0, 4);
    lat = 1;
  endtask

  task automatic test_branch_stall_hold();
    int n = 0;
    int bad = 0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    stall = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (fd_flag !== 1'b0 || imem_addr !== 32'h104) begin
      n_err++;
      $display("FAIL bh_hold: got flag=%b addr=%h want 0 00000104", fd_flag, imem_addr);
    end
    branch_taken = 1'b1;
    branch_target = 32'h00002000;
    cyc();
    branch_taken = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if ({fd_flag, fd_pc_replace} !== 2'b11 || fd_idata !== memf(32'h100) || fd_iaddr !== 32'h100) begin
      n_err++;
      $display("FAIL bh_flush: got flag=%b rep=%b data=%h addr=%h want 1 1 data=%h addr=00000100",
               fd_flag, fd_pc_replace, fd_idata, fd_iaddr, memf(32'h100));
    end
    n = 0;
    do begin cyc(); n++; if (fd_flag !== 1'b0) bad++; end while (!imem_req && n < 20);
    n_cmp++;
    if (bad != 0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      n_err++;
      $display("FAIL bh_redirect: got strobes=%0d req=%b addr=%h want 0 1 00002000", bad, imem_req, imem_addr);
    end
    fetch_one(32'h2000, 0, 2);
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1;
    branch_target = 32'hFFFFFFFE;
    cyc();
    branch_taken = 1'b0;
    n_cmp++;
    if ({fd_flag, fd_pc_replace} !== 2'b11 || fd_iaddr !== 32'h2000) begin
      n_err++;
      $display("FAIL wrap_flush: got flag=%b rep=%b addr=%h want 1 1 00002000", fd_flag, fd_pc_replace, fd_iaddr);
    end
    fetch_one(32'hFFFFFFFC, 1, 2);
    fetch_one(32'h0, 1, 2);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    mem_en = 1'b0;
    imem_valid = 1'b0;
    while (!imem_req && n < 20) begin cyc(); n++; end
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL rm_req: got req=%b addr=%h want addr=00000004", imem_req, imem_addr);
    end
    reset = 1'b1;
    #1;
    if ({imem_req, imem_addr, fd_flag, fd_pc_replace, fd_idata, fd_iaddr} !== '0) bad++;
    repeat (2) begin
      cyc();
      if ({imem_req, imem_addr, fd_flag, fd_pc_replace, fd_idata, fd_iaddr} !== '0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rm_zero: got %0d nonzero samples want 0", bad);
    end
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    cyc();
    imem_valid = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fd_flag !== 1'b0) begin
      n_err++;
      $display("FAIL rm_fresh: got req=%b addr=%h flag=%b want 1 00000000 0", imem_req, imem_addr, fd_flag);
    end
    cyc();
    bad = (fd_flag !== 1'b0) ? 1 : 0;
    imem_valid = 1'b1;
    imem_rdata = memf(32'h0);
    cyc();
    imem_valid = 1'b0;
    n_cmp++;
    if (bad != 0 || {fd_flag, fd_pc_replace} !== 2'b10 || fd_idata !== memf(32'h0) || fd_iaddr !== 32'h0) begin
      n_err++;
      $display("FAIL rm_deliver: got stale=%0d flag=%b rep=%b data=%h addr=%h want 0 1 0 %h 00000000",
               bad, fd_flag, fd_pc_replace, fd_idata, fd_iaddr, memf(32'h0));
    end
    mem_en = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h4;
    logic [31:0] last_d = memf(32'h0);
    logic [31:0] last_a = 32'h0;
    logic        prev_b;
    logic        prev_s;
    logic [31:0] prev_t;
    int delivered = 0;
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      branch_taken  = ($urandom_range(0, 99) < 6);
      branch_target = $urandom;
      stall         = ($urandom_range(0, 99) < 30);
      prev_b = branch_taken;
      prev_s = stall;
      prev_t = branch_target;
      cyc();
      n_cmp++;
      if ((fd_flag && fd_pc_replace) !== prev_b) begin
        n_err++;
        $display("FAIL rnd_flush @%0d: got flag=%b rep=%b want flush=%b", i, fd_flag, fd_pc_replace, prev_b);
      end
      if (fd_flag && fd_pc_replace) begin
        n_cmp++;
        if (fd_idata !== last_d || fd_iaddr !== last_a) begin
          n_err++;
          $display("FAIL rnd_flush_hold @%0d: got %h/%h want %h/%h", i, fd_idata, fd_iaddr, last_d, last_a);
        end
        exp_pc = {prev_t[31:2], 2'b00};
      end else if (fd_flag) begin
        n_cmp++;
        if (prev_s || fd_iaddr !== exp_pc || fd_idata !== memf(exp_pc)) begin
          n_err++;
          $display("FAIL rnd_deliver @%0d: got stall=%b data=%h addr=%h want 0 %h %h", i, prev_s, fd_idata, fd_iaddr, memf(exp_pc), exp_pc);
        end
        last_d = memf(exp_pc);
        last_a = exp_pc;
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (imem_req) begin
        n_cmp++;
        if (imem_addr !== exp_pc) begin
          n_err++;
          $display("FAIL rnd_req @%0d: got %h want %h", i, imem_addr, exp_pc);
        end
      end
    end
    branch_taken = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if (overlap != 0 || delivered < 50) begin
      n_err++;
      $display("FAIL rnd_progress: got overlap=%0d delivered=%0d want 0 and >=50", overlap, delivered);
    end
  endtask

  initial begin
    mem[32'h0] = 32'h00500093;
    mem[32'h4] = 32'h00A00113;
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_branch_stall_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch producer for the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Captures returned instructions and delivers them, with their addresses, to IF/ID using a one-cycle load strobe.
- Handles decode-side stalls by buffering, and handles branch redirects by flushing IF/ID (NOP insert) and discarding in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: IF/ID must not be loaded this cycle
- branch_taken  in  1  redirect request, sampled each rising edge
- branch_target  in  32  redirect PC; bits [1:0] ignored and treated as 0
- imem_req  out  1  single-cycle request pulse
- imem_addr  out  32  request address; valid while imem_req=1
- imem_valid  in  1  response strobe; arrives at least 1 cycle after imem_req
- imem_rdata  in  32  instruction word; valid with imem_valid
- fd_flag  out  1  one-cycle strobe: IF/ID loads this cycle
- fd_pc_replace  out  1  with fd_flag: IF/ID loads NOP instead of fd_idata
- fd_idata  out  32  instruction to IF/ID
- fd_iaddr  out  32  address of fd_idata

Behaviour:
- All outputs are registered.
- Reset values: pc=RESET_PC, state=FETCH, drop=0, imem_req=0, imem_addr=0, fd_flag=0, fd_pc_replace=0, fd_idata=0, fd_iaddr=0.
- Reset mid-operation aborts everything. A later imem_valid for a pre-reset request is ignored, because only WAIT accepts responses.
- States:
  - FETCH: issue a request (imem_req=1, imem_addr=pc on the next edge's outputs). Next state WAIT.
  - WAIT: one request outstanding.
  - HOLD: instruction captured, blocked by stall.
- WAIT, imem_valid=1, drop=0, stall=0:
  - next cycle fd_flag=1, fd_pc_replace=0, fd_idata=imem_rdata, fd_iaddr=pc.
  - pc <= pc+4, wrapping mod 2^32 (32'hFFFFFFFC -> 0). Next state FETCH.
- WAIT, imem_valid=1, drop=0, stall=1: buffer rdata and pc. Next state HOLD. No strobe.
- WAIT, imem_valid=1, drop=1: discard the response, clear drop. Next state FETCH. No strobe.
- HOLD, stall=0: next cycle fd_flag=1 with buffered data and address; pc <= pc+4. Next state FETCH.
- HOLD, stall=1: remain in HOLD, outputs unchanged.
- imem_valid outside WAIT is ignored.
- fd_flag is a single-cycle pulse. fd_idata and fd_iaddr hold their last values while fd_flag=0.
- Branch redirect (branch_taken=1) has priority over stall and over response handling:
  - pc <= {branch_target[31:2],2'b00}.
  - Next cycle fd_flag=1, fd_pc_replace=1; fd_idata and fd_iaddr are unchanged.
  - From FETCH or HOLD: go to FETCH; any HOLD buffer is discarded.
  - From WAIT with imem_valid=1 in the same cycle: the response is discarded; go to FETCH.
  - From WAIT with imem_valid=0: set drop=1 and stay in WAIT. The next response is discarded, then fetch resumes at the target.
  - Back-to-back redirects: the last one wins. Each one produces its own flush strobe.
- Fetch latency: on a 1-cycle memory, the request-to-strobe interval is 2 cycles, so throughput is 1 instruction per 3 cycles. Exactly one request is outstanding at any time.

Test Plan:
- Reset release with RESET_PC=0, 1-cycle memory returning 32'h00500093 then 32'h00A00113 -> imem_addr 0 then 4; fd_flag pulses deliver (00500093, 0) then (00A00113, 4); fd_pc_replace=0.
- stall=1 held for 4 cycles while the response for addr 8 returns -> no fd_flag during the stall. On the first cycle after stall drops, fd_flag=1 with the buffered word and fd_iaddr=8. The next request is to addr 12.
- branch_taken with branch_target=32'h00000103 while WAIT for addr 16 (3-cycle memory) -> next cycle fd_flag=1 and fd_pc_replace=1. The addr-16 response is discarded with no strobe. The next imem_addr is 32'h00000100.
- branch_taken and stall asserted together in HOLD -> flush strobe is issued, the buffer is discarded, and the next request goes to the target.
- PC at 32'hFFFFFFFC -> instruction delivered with fd_iaddr=FFFFFFFC; the next imem_addr is 0.
- Reset asserted while in WAIT, with the response arriving 1 cycle after release -> the response is ignored, a fresh request goes to RESET_PC, and all outputs are 0 during reset.
